// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants for the two-requester RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address / data widths
//   DEPTH                   : RAM depth at the default address width
//   ST_INIT / ST_RUN        : controller states (ST_INIT only used with MEM_ARBITER_INIT_EN)
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH      = 1 << ADDR_W_DEF;

  typedef logic [0:0] state_t;

  localparam state_t ST_INIT = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant, purely combinational.
//   i_valid0/1  : request valids
//   i_hs        : a handshake happens this cycle (granted valid is accepted)
//   i_ptr       : last-grant pointer (0 = req0 granted last, 1 = req1)
//   o_grant     : one-hot grant, zero when nobody is valid
//   o_ptr_next  : pointer value to register at the next edge
module rr_arb2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_hs,
  input  logic       i_ptr,
  output logic [1:0] o_grant,
  output logic       o_ptr_next
);

  always_comb begin
    // On a tie the requester that was not granted last wins.
    o_grant[0] = i_valid0 & (~i_valid1 | i_ptr);
    o_grant[1] = i_valid1 & (~i_valid0 | ~i_ptr);
    o_ptr_next = i_hs ? o_grant[1] : i_ptr;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM (combinational read, level write) between two
// masters with round-robin arbitration, one RAM access per cycle, and per-requester read
// response strobes two cycles after the handshake.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   reqX_valid/ready/wr/adr/wdata : request channel of requester X (ready is combinational)
//   reqX_rdata/rvalid           : read data and its one-cycle valid strobe
//   ram_adr/din/wr/cs, ram_dout : RAM pins (this block is their only driver)
//   busy                        : high while the controller is clearing the RAM
// Optional feature: define MEM_ARBITER_INIT_EN to zero the whole RAM after every reset.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_adr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_rvalid,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_adr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_rvalid,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wr,
  output logic              ram_cs,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  logic              w_init;
  logic              w_run;
  logic [ADDR_W-1:0] w_init_adr;
  logic [1:0]        w_grant;
  logic              w_hs0;
  logic              w_hs1;
  logic              w_ptr_next;

  logic              r_ptr;
  logic              r_rd_pend0;
  logic              r_rd_pend1;
  logic [ADDR_W-1:0] r_ram_adr;
  logic [DATA_W-1:0] r_ram_din;
  logic              r_ram_wr;
  logic              r_ram_cs;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_rvalid0;
  logic              r_rvalid1;

`ifdef MEM_ARBITER_INIT_EN
  state_t            r_state;
  logic [ADDR_W-1:0] r_init_cnt;

  // Sweep every address once; the last address moves the controller to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
      if (&r_init_cnt) begin
        r_state <= ST_RUN;
      end
    end
  end

  assign w_init     = (r_state == ST_INIT);
  assign w_init_adr = r_init_cnt;
`else
  assign w_init     = 1'b0;
  assign w_init_adr = '0;
`endif

  assign w_run = ~w_init;
  assign busy  = w_init;

  rr_arb2 u_arb (
    .i_valid0   (req0_valid),
    .i_valid1   (req1_valid),
    .i_hs       (w_hs0 | w_hs1),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_ptr_next (w_ptr_next)
  );

  assign req0_ready = w_run & w_grant[0];
  assign req1_ready = w_run & w_grant[1];
  assign w_hs0      = req0_valid & req0_ready;
  assign w_hs1      = req1_valid & req1_ready;

  // RAM command register: at most one source per cycle (init sweep or one handshake).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_adr <= '0;
      r_ram_din <= '0;
      r_ram_wr  <= 1'b0;
      r_ram_cs  <= 1'b0;
    end else if (w_init) begin
      r_ram_adr <= w_init_adr;
      r_ram_din <= '0;
      r_ram_wr  <= 1'b1;
      r_ram_cs  <= 1'b1;
    end else if (w_hs0) begin
      r_ram_adr <= req0_adr;
      r_ram_din <= req0_wdata;
      r_ram_wr  <= req0_wr;
      r_ram_cs  <= 1'b1;
    end else if (w_hs1) begin
      r_ram_adr <= req1_adr;
      r_ram_din <= req1_wdata;
      r_ram_wr  <= req1_wr;
      r_ram_cs  <= 1'b1;
    end else begin
      r_ram_wr  <= 1'b0;
      r_ram_cs  <= 1'b0;
    end
  end

  // Read response: the RAM address is live for one cycle, capture its data at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= 1'b1;
      r_rd_pend0 <= 1'b0;
      r_rd_pend1 <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
    end else begin
      r_ptr      <= w_ptr_next;
      r_rd_pend0 <= w_hs0 & ~req0_wr;
      r_rd_pend1 <= w_hs1 & ~req1_wr;
      r_rvalid0  <= r_rd_pend0;
      r_rvalid1  <= r_rd_pend1;
      if (r_rd_pend0) begin
        r_rdata0 <= ram_dout;
      end
      if (r_rd_pend1) begin
        r_rdata1 <= ram_dout;
      end
    end
  end

  assign ram_adr     = r_ram_adr;
  assign ram_din     = r_ram_din;
  assign ram_wr      = r_ram_wr;
  assign ram_cs      = r_ram_cs;
  assign req0_rdata  = r_rdata0;
  assign req1_rdata  = r_rdata1;
  assign req0_rvalid = r_rvalid0;
  assign req1_rvalid = r_rvalid1;

endmodule
